// File: rtl/mdom_wvb_acq_ctrl.sv
// Acquisition sequencer for one mDOM waveform-buffer channel: decides which ADC samples
// are written to the WVB and emits one header handshake per captured event.
module mdom_wvb_acq_ctrl #(
  parameter int LEN_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             trig_mode,
  input  logic             cnst_run,
  input  logic [4:0]       pre_conf,
  input  logic [7:0]       post_conf,
  input  logic [11:0]      cnst_conf,
  input  logic [11:0]      test_conf,
  input  logic             disc_trig,
  input  logic             sw_trig,
  input  logic             wvb_full,
  input  logic             hdr_ready,
  output logic             wvb_wr_en,
  output logic             hdr_valid,
  output logic [LEN_W-1:0] hdr_len,
  output logic             hdr_trunc,
  output logic [1:0]       hdr_src,
  output logic             armed,
  output logic             overflow
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PRE     = 3'd1;
  localparam logic [2:0] S_ARMED   = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_HDR     = 3'd4;

  localparam logic [1:0] SRC_DISC = 2'd0;
  localparam logic [1:0] SRC_TEST = 2'd1;
  localparam logic [1:0] SRC_SW   = 2'd2;
  localparam logic [1:0] SRC_CNST = 2'd3;

  // Header handshake: hdr_valid rises in the cycle after capture ends and stays high,
  // with hdr_len/hdr_trunc/hdr_src frozen, until the cycle in which hdr_ready is seen high.

  logic [2:0]       state, state_n;
  logic [4:0]       pre_cnt;
  logic [11:0]      test_cnt;
  logic [LEN_W-1:0] smp_cnt, smp_nxt, rec_len;
  logic             disc_q, capture_q;
  logic             disc_rise, trig, cap_done;

  logic [4:0]       pre_s;
  logic [7:0]       post_s;
  logic [11:0]      cnst_s, test_s;
  logic             mode_s, cnst_run_s;

  // A full WVB must never see a write strobe, so the registered capture flag is masked
  // by wvb_full in the same cycle.
  assign wvb_wr_en = capture_q & ~wvb_full;

  always_comb begin
    disc_rise = disc_trig & ~disc_q;
    trig      = sw_trig | (mode_s ? (test_cnt == test_s) : disc_rise);
    rec_len   = cnst_run_s ? (LEN_W'(cnst_s) + LEN_W'(1))
                           : (LEN_W'(pre_s) + LEN_W'(post_s) + LEN_W'(1));
    smp_nxt   = smp_cnt + LEN_W'(1);
    cap_done  = wvb_full || (smp_nxt == rec_len);
    state_n   = state;
    case (state)
      S_IDLE: begin
        if (arm) begin
          if (pre_conf != 5'd0) state_n = S_PRE;
          else if (cnst_run)    state_n = S_CAPTURE;
          else                  state_n = S_ARMED;
        end
      end
      S_PRE: begin
        if (!arm)                  state_n = S_IDLE;
        else if (pre_cnt == 5'd0)  state_n = cnst_run_s ? S_CAPTURE : S_ARMED;
      end
      S_ARMED: begin
        if (!arm)                  state_n = S_IDLE;
        else if (trig && !wvb_full) state_n = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (cap_done) state_n = S_HDR;
      end
      S_HDR: begin
        if (hdr_ready) begin
          if (!arm)            state_n = S_IDLE;
          else if (cnst_run_s) state_n = S_CAPTURE;
          else                 state_n = S_ARMED;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pre_cnt    <= '0;
      test_cnt   <= '0;
      smp_cnt    <= '0;
      disc_q     <= 1'b0;
      capture_q  <= 1'b0;
      hdr_valid  <= 1'b0;
      hdr_len    <= '0;
      hdr_trunc  <= 1'b0;
      hdr_src    <= '0;
      armed      <= 1'b0;
      overflow   <= 1'b0;
      pre_s      <= '0;
      post_s     <= '0;
      cnst_s     <= '0;
      test_s     <= '0;
      mode_s     <= 1'b0;
      cnst_run_s <= 1'b0;
    end else begin
      state     <= state_n;
      disc_q    <= disc_trig;
      capture_q <= (state_n == S_CAPTURE);
      hdr_valid <= (state_n == S_HDR);
      armed     <= (state_n == S_ARMED);
      test_cnt  <= (state == S_ARMED) ? test_cnt + 12'd1 : 12'd0;

      // Settings are frozen for the whole armed session; later changes wait for the next arm.
      if (state == S_IDLE && arm) begin
        pre_s      <= pre_conf;
        post_s     <= post_conf;
        cnst_s     <= cnst_conf;
        test_s     <= test_conf;
        mode_s     <= trig_mode;
        cnst_run_s <= cnst_run;
        pre_cnt    <= pre_conf - 5'd1;
      end else if (state == S_PRE) begin
        pre_cnt <= pre_cnt - 5'd1;
      end

      if (state == S_CAPTURE) begin
        if (!wvb_full) smp_cnt <= smp_nxt;
      end else begin
        smp_cnt <= '0;
      end

      if (state == S_CAPTURE && cap_done) begin
        hdr_len   <= wvb_full ? smp_cnt : smp_nxt;
        hdr_trunc <= wvb_full;
      end

      if (state_n == S_CAPTURE && state != S_CAPTURE) begin
        if (state == S_ARMED) hdr_src <= sw_trig ? SRC_SW : (mode_s ? SRC_TEST : SRC_DISC);
        else                  hdr_src <= SRC_CNST;
      end

      if (state == S_IDLE)
        overflow <= 1'b0;
      else if (wvb_full && ((state == S_ARMED && arm && trig) || state == S_CAPTURE))
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mdom_wvb_acq_ctrl.sv
// Bench for mdom_wvb_acq_ctrl: directed scenarios feed an expected burst-start queue and
// an expected header queue; a negedge monitor pops and compares as the DUT produces them.
module tb_mdom_wvb_acq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm, trig_mode, cnst_run;
  logic [4:0]  pre_conf;
  logic [7:0]  post_conf;
  logic [11:0] cnst_conf, test_conf;
  logic        disc_trig, sw_trig, wvb_full, hdr_ready;
  logic        wvb_wr_en, hdr_valid, hdr_trunc, armed, overflow;
  logic [12:0] hdr_len;
  logic [1:0]  hdr_src;

  mdom_wvb_acq_ctrl #(.LEN_W(13)) dut (
    .clk(clk), .rst(rst), .arm(arm), .trig_mode(trig_mode), .cnst_run(cnst_run),
    .pre_conf(pre_conf), .post_conf(post_conf), .cnst_conf(cnst_conf), .test_conf(test_conf),
    .disc_trig(disc_trig), .sw_trig(sw_trig), .wvb_full(wvb_full), .hdr_ready(hdr_ready),
    .wvb_wr_en(wvb_wr_en), .hdr_valid(hdr_valid), .hdr_len(hdr_len), .hdr_trunc(hdr_trunc),
    .hdr_src(hdr_src), .armed(armed), .overflow(overflow)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int fails  = 0;
  logic [15:0] exp_q[$];     // {len[12:0], trunc, src[1:0]}
  logic [31:0] start_q[$];   // expected cycle of each burst's first write
  int wr_cnt   = 0;
  int n_bursts = 0;
  logic wr_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      wr_cnt  = 0;
      wr_prev = 1'b0;
    end else begin
      if (wvb_wr_en && !wr_prev) begin
        n_bursts++;
        if (start_q.size() == 0) chk("unexpected_burst", cyc, 0);
        else                     chk("burst_start", cyc, start_q.pop_front());
      end
      if (wvb_wr_en) wr_cnt++;
      wr_prev = wvb_wr_en;
      if (hdr_valid && hdr_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_hdr", hdr_len, 0);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          chk("hdr_len",    hdr_len,   e[15:3]);
          chk("hdr_trunc",  hdr_trunc, e[2]);
          chk("hdr_src",    hdr_src,   e[1:0]);
          chk("hdr_writes", wr_cnt,    e[15:3]);
        end
        wr_cnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || start_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    if (exp_q.size() != 0 || start_q.size() != 0) begin
      chk("timeout_pending", exp_q.size() + start_q.size(), 0);
      exp_q.delete();
      start_q.delete();
    end
  endtask

  task automatic set_cfg(input logic [4:0] pre, input logic [7:0] post, input logic mode,
                         input logic cnst, input logic [11:0] cconf, input logic [11:0] tconf);
    pre_conf  = pre;
    post_conf = post;
    trig_mode = mode;
    cnst_run  = cnst;
    cnst_conf = cconf;
    test_conf = tconf;
  endtask

  task automatic disarm();
    arm       = 1'b0;
    disc_trig = 1'b0;
    sw_trig   = 1'b0;
    wvb_full  = 1'b0;
    hdr_ready = 1'b1;
    repeat (3) step();
    chk("disarm_armed", armed, 0);
    chk("disarm_wr_en", wvb_wr_en, 0);
  endtask

  // ---------------- stimulus ----------------
  int a;
  int b0;

  initial begin
    rst = 1'b1; arm = 1'b0; disc_trig = 1'b0; sw_trig = 1'b0; wvb_full = 1'b0;
    hdr_ready = 1'b1;
    set_cfg(5'd0, 8'd0, 1'b0, 1'b0, 12'd0, 12'd0);
    repeat (3) step();
    chk("rst_wr_en", wvb_wr_en, 0);
    chk("rst_hdr_valid", hdr_valid, 0);
    chk("rst_armed", armed, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_hdr_len", hdr_len, 0);
    rst = 1'b0;
    repeat (2) step();

    // 1: pre=4 post=10, disc edge 6 cycles after arm -> 15 writes from edge+1
    set_cfg(5'd4, 8'd10, 1'b0, 1'b0, 12'd0, 12'd0);
    a = cyc; arm = 1'b1;
    goto(a + 5);
    chk("t1_armed", armed, 1);
    goto(a + 6);
    start_q.push_back(a + 7);
    exp_q.push_back({13'd15, 1'b0, 2'd0});
    disc_trig = 1'b1;
    wait_done(100);
    disarm();

    // 2: disc edge during PRE, held high into ARMED -> no event
    set_cfg(5'd20, 8'd10, 1'b0, 1'b0, 12'd0, 12'd0);
    b0 = n_bursts;
    a = cyc; arm = 1'b1;
    goto(a + 5);
    disc_trig = 1'b1;
    goto(a + 40);
    chk("t2_armed", armed, 1);
    chk("t2_no_burst", n_bursts - b0, 0);
    arm = 1'b0;
    step();
    chk("t2_arm_drop", armed, 0);
    disarm();

    // 3: periodic test trigger, period = 100 armed + capture + header = 102
    set_cfg(5'd0, 8'd0, 1'b1, 1'b0, 12'd0, 12'd99);
    a = cyc; arm = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_q.push_back(a + 101 + 102 * k);
      exp_q.push_back({13'd1, 1'b0, 2'd1});
    end
    wait_done(400);
    disarm();

    // 3b: sw and disc in the same cycle -> single event, sw wins the source
    set_cfg(5'd0, 8'd3, 1'b0, 1'b0, 12'd0, 12'd0);
    a = cyc; arm = 1'b1;
    goto(a + 3);
    start_q.push_back(a + 4);
    exp_q.push_back({13'd4, 1'b0, 2'd2});
    disc_trig = 1'b1; sw_trig = 1'b1;
    step();
    sw_trig = 1'b0;
    wait_done(50);
    disarm();

    // 4: constant run, 4096-sample records back to back; triggers ignored; arm drops mid-record
    set_cfg(5'd0, 8'd0, 1'b0, 1'b1, 12'd4095, 12'd0);
    b0 = n_bursts;
    a = cyc; arm = 1'b1;
    start_q.push_back(a + 1);
    start_q.push_back(a + 4098);
    exp_q.push_back({13'd4096, 1'b0, 2'd3});
    exp_q.push_back({13'd4096, 1'b0, 2'd3});
    goto(a + 100);
    sw_trig = 1'b1;
    step();
    sw_trig = 1'b0;
    goto(a + 200);
    disc_trig = 1'b1;
    goto(a + 5000);
    arm = 1'b0;
    wait_done(4000);
    goto(a + 8200);
    chk("t4_bursts", n_bursts - b0, 2);
    chk("t4_idle_armed", armed, 0);
    disarm();

    // 5: wvb_full on 6th capture cycle -> 5 writes, truncated; overflow sticky till IDLE
    set_cfg(5'd0, 8'd9, 1'b0, 1'b0, 12'd0, 12'd0);
    a = cyc; arm = 1'b1;
    goto(a + 2);
    chk("t5_ovf_clear", overflow, 0);
    goto(a + 3);
    start_q.push_back(a + 4);
    exp_q.push_back({13'd5, 1'b1, 2'd2});
    sw_trig = 1'b1;
    step();
    sw_trig = 1'b0;
    goto(a + 9);
    wvb_full = 1'b1;
    step();
    wvb_full = 1'b0;
    wait_done(50);
    goto(a + 12);
    chk("t5_overflow", overflow, 1);
    goto(a + 15);
    b0 = n_bursts;
    wvb_full = 1'b1; sw_trig = 1'b1;
    step();
    wvb_full = 1'b0; sw_trig = 1'b0;
    repeat (5) step();
    chk("t5_full_trig_rejected", n_bursts - b0, 0);
    chk("t5_still_armed", armed, 1);
    chk("t5_overflow_hold", overflow, 1);
    disarm();
    chk("t5_overflow_idle", overflow, 0);

    // 6: arm drops mid-capture, header held 50 cycles without ready
    set_cfg(5'd2, 8'd5, 1'b0, 1'b0, 12'd0, 12'd0);
    hdr_ready = 1'b0;
    a = cyc; arm = 1'b1;
    goto(a + 4);
    start_q.push_back(a + 5);
    exp_q.push_back({13'd8, 1'b0, 2'd0});
    disc_trig = 1'b1;
    goto(a + 7);
    arm = 1'b0;
    goto(a + 13);
    for (int k = 0; k < 50; k++) begin
      chk("t6_hdr_valid_hold", hdr_valid, 1);
      chk("t6_hdr_len_hold", hdr_len, 8);
      step();
    end
    hdr_ready = 1'b1;
    step();
    chk("t6_hdr_dropped", hdr_valid, 0);
    chk("t6_idle", armed, 0);
    wait_done(10);
    disarm();

    // 7: reset mid-capture -> outputs clear at once, no header
    set_cfg(5'd0, 8'd30, 1'b0, 1'b0, 12'd0, 12'd0);
    a = cyc; arm = 1'b1;
    goto(a + 2);
    start_q.push_back(a + 3);
    sw_trig = 1'b1;
    step();
    sw_trig = 1'b0;
    goto(a + 10);
    rst = 1'b1;
    #1;
    chk("t7_rst_wr_en", wvb_wr_en, 0);
    chk("t7_rst_hdr_valid", hdr_valid, 0);
    chk("t7_rst_armed", armed, 0);
    arm = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    repeat (40) step();
    chk("t7_no_hdr", hdr_valid, 0);
    wait_done(5);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
